// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Decode a destination index into a register mask. x0 is hardwired
    // and never represents a real pending write, so its bit stays clear.
    function automatic logic [NUM_REGS-1:0] onehot_rd(input logic [ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (rd != '0) begin
            mask[rd] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/register-file bundle for the writeback arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both producer channels.
// Ports: alu_* and mem_* producer channels, write_* register-file port,
// pending hazard mask. "master" is the producer/consumer side, "slave" the arbiter.
interface wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_d;
    logic              reg_write;
    logic [31:0]       pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  write_reg, write_d, reg_write, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output write_reg, write_d, reg_write, pending
    );
endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO of wb_entry_t with per-slot visibility for hazard tracking.
// Latency: entry visible at head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, rst_n, push/din, pop, head, full, empty, slot_vld/slot_rd.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    din,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             slot_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] slot_rd
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    wb_entry_t   mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // A slot is live when its distance from the read index is below the
    // occupancy count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign slot_vld[g] = ({1'b0, AW'(g) - rd_ptr[AW-1:0]} < count);
        assign slot_rd[g]  = mem[g].rd;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU (priority) and buffered load results share the register-file write port.
// Latency: ALU 1 cycle to write port; loads >= 2 cycles (enqueue, dequeue, write).
// Backpressure: alu_ready drops for one cycle after STARVE_LIMIT ALU wins over a waiting load; mem_ready = !fifo_full.
// Ports: clk, rst_n (async active-low), bus (wb_arbiter_if.slave).
module wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    import wb_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Starvation state is fully implied by the counter and FIFO occupancy.
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_DRAIN  = 1'b1;

    wb_entry_t                              fifo_din;
    wb_entry_t                              fifo_head;
    logic                                   fifo_full;
    logic                                   fifo_empty;
    logic [FIFO_DEPTH-1:0]                  slot_vld;
    logic [FIFO_DEPTH-1:0][wb_pkg::ADDR_W-1:0] slot_rd;

    logic [CW-1:0]      starve_cnt;
    logic [0:0]         arb_state;
    logic               alu_xfer;
    logic               enq;
    logic               deq;

    logic [ADDR_W-1:0]  write_reg_q;
    logic [DATA_W-1:0]  write_d_q;
    logic               reg_write_q;
    logic [NUM_REGS-1:0] pending_mask;

    assign fifo_din = '{rd: bus.mem_rd, data: bus.mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (enq),
        .din      (fifo_din),
        .pop      (deq),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .slot_vld (slot_vld),
        .slot_rd  (slot_rd)
    );

    // Readies depend only on registered state, keeping inputs off every output path.
    assign arb_state     = (!fifo_empty && (starve_cnt == LIMIT)) ? ST_DRAIN : ST_NORMAL;
    assign bus.alu_ready = (arb_state == ST_NORMAL);
    assign bus.mem_ready = !fifo_full;

    assign alu_xfer = bus.alu_valid && bus.alu_ready;
    assign enq      = bus.mem_valid && !fifo_full;
    // Dequeue decision uses pre-edge occupancy, so a load pushed into an
    // empty FIFO waits until the following edge.
    assign deq      = !alu_xfer && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || deq) begin
            starve_cnt <= '0;
        end else if (alu_xfer && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // x0 entries are consumed like any other but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg_q <= '0;
            write_d_q   <= '0;
            reg_write_q <= 1'b0;
        end else if (alu_xfer) begin
            write_reg_q <= bus.alu_rd;
            write_d_q   <= bus.alu_data;
            reg_write_q <= (bus.alu_rd != '0);
        end else if (deq) begin
            write_reg_q <= fifo_head.rd;
            write_d_q   <= fifo_head.data;
            reg_write_q <= (fifo_head.rd != '0);
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_vld[i]) begin
                pending_mask = pending_mask | onehot_rd(slot_rd[i]);
            end
        end
        if (reg_write_q) begin
            pending_mask = pending_mask | onehot_rd(write_reg_q);
        end
    end

    assign bus.write_reg = write_reg_q;
    assign bus.write_d   = write_d_q;
    assign bus.reg_write = reg_write_q;
    assign bus.pending   = pending_mask;

endmodule
